stacker_frame_painter: RTL and testbench

Upstream stage of vga_frame_driver. Renders the stacker game grid (16 x 12 virtual cells, 40x40 screen pixels each) into the draw-frame memory through the driver's pixel write port. Writes one cell per clock in column-major order. Optionally holds off until a frame boundary so the driver never reads a half-repainted frame.

---
 rtl/stacker_frame_painter_if.sv | 42 ++++
 rtl/stacker_frame_painter.sv | 169 ++++++++++++++++
 tb/tb_stacker_frame_painter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stacker_frame_painter_if.sv
// rtl/stacker_frame_painter_if.sv - game-state inputs and draw-frame pixel write port of the painter
interface stacker_frame_painter_if #(
    parameter int GRID_COLS = 16,
    parameter int GRID_ROWS = 12
);
    logic                           draw_start;
    logic [GRID_COLS*GRID_ROWS-1:0] grid_bits;
    logic [3:0]                     active_row;
    logic                           game_over;
    logic                           frame_done;
    logic                           busy;
    logic                           draw_done;
    logic [14:0]                    the_vga_draw_frame_write_mem_address;
    logic [23:0]                    the_vga_draw_frame_write_mem_data;
    logic                           the_vga_draw_frame_write_a_pixel;

    modport master (
        input  draw_start,
        input  grid_bits,
        input  active_row,
        input  game_over,
        input  frame_done,
        output busy,
        output draw_done,
        output the_vga_draw_frame_write_mem_address,
        output the_vga_draw_frame_write_mem_data,
        output the_vga_draw_frame_write_a_pixel
    );

    modport slave (
        output draw_start,
        output grid_bits,
        output active_row,
        output game_over,
        output frame_done,
        input  busy,
        input  draw_done,
        input  the_vga_draw_frame_write_mem_address,
        input  the_vga_draw_frame_write_mem_data,
        input  the_vga_draw_frame_write_a_pixel
    );
endinterface

// File: rtl/stacker_frame_painter.sv
// rtl/stacker_frame_painter.sv - paints the stacker grid into the VGA draw frame, one cell per clock
module stacker_frame_painter #(
    parameter int          GRID_COLS     = 16,
    parameter int          GRID_ROWS     = 12,
    parameter logic [23:0] BG_COLOR      = 24'h000000,
    parameter logic [23:0] STACK_COLOR   = 24'h00FF00,
    parameter logic [23:0] ACTIVE_COLOR  = 24'hFF0000,
    parameter logic [23:0] OVER_COLOR    = 24'hFFFFFF,
    parameter bit          SYNC_TO_FRAME = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    stacker_frame_painter_if.master bus
);
    localparam int NCELLS = GRID_COLS * GRID_ROWS;
    localparam int CW     = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int RW     = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int IW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, PAINT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic               pending_q, pending_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wr_q, wr_d;
    logic [14:0]        addr_q, addr_d;
    logic [23:0]        data_q, data_d;
    logic [NCELLS-1:0]  grid_q, grid_d;
    logic [3:0]         act_q, act_d;
    logic               over_q, over_d;

    logic               start_paint;
    logic [14:0]        cell_addr;
    logic [IW-1:0]      bit_idx;
    logic [23:0]        cell_color;

    // Memory is column-major, occupancy bits are row-major.
    assign cell_addr = 15'(col_q) * 15'(GRID_ROWS) + 15'(row_q);
    assign bit_idx   = IW'(row_q) * IW'(GRID_COLS) + IW'(col_q);

    always_comb begin
        cell_color = BG_COLOR;
        if (grid_q[bit_idx]) begin
            if (over_q)
                cell_color = OVER_COLOR;
            else if (32'(row_q) == 32'(act_q))
                cell_color = ACTIVE_COLOR;
            else
                cell_color = STACK_COLOR;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        pending_d   = pending_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        wr_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        grid_d      = grid_q;
        act_d       = act_q;
        over_d      = over_q;
        start_paint = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.draw_start) begin
                    busy_d = 1'b1;
                    if (SYNC_TO_FRAME)
                        state_d = WAIT_SYNC;
                    else
                        start_paint = 1'b1;
                end
            end
            WAIT_SYNC: begin
                busy_d = 1'b1;
                if (bus.draw_start)
                    pending_d = 1'b1;
                if (bus.frame_done)
                    start_paint = 1'b1;
            end
            PAINT: begin
                busy_d = 1'b1;
                if (bus.draw_start)
                    pending_d = 1'b1;
                wr_d   = 1'b1;
                addr_d = cell_addr;
                data_d = cell_color;
                if (row_q == RW'(GRID_ROWS - 1)) begin
                    row_d = '0;
                    if (col_q == CW'(GRID_COLS - 1)) begin
                        col_d   = '0;
                        state_d = DONE;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            DONE: begin
                // busy drops for the draw_done cycle even when a repaint follows.
                done_d = 1'b1;
                busy_d = 1'b0;
                if (pending_q || bus.draw_start) begin
                    pending_d = 1'b0;
                    if (SYNC_TO_FRAME)
                        state_d = WAIT_SYNC;
                    else
                        start_paint = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_paint) begin
            state_d = PAINT;
            col_d   = '0;
            row_d   = '0;
            grid_d  = bus.grid_bits;
            act_d   = bus.active_row;
            over_d  = bus.game_over;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            grid_q    <= '0;
            act_q     <= '0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            grid_q    <= grid_d;
            act_q     <= act_d;
            over_q    <= over_d;
        end
    end

    assign bus.busy                                 = busy_q;
    assign bus.draw_done                            = done_q;
    assign bus.the_vga_draw_frame_write_a_pixel     = wr_q;
    assign bus.the_vga_draw_frame_write_mem_address = addr_q;
    assign bus.the_vga_draw_frame_write_mem_data    = data_q;
endmodule

// File: tb/tb_stacker_frame_painter.sv
// tb/tb_stacker_frame_painter.sv - bench for stacker_frame_painter, free-running and frame-synced instances
module tb_stacker_frame_painter;
    localparam int COLS = 16;
    localparam int ROWS = 12;
    localparam int NC   = COLS * ROWS;

    typedef struct packed {
        logic [14:0] addr;
        logic [23:0] data;
    } wr_t;

    typedef struct {
        int          col;
        int          row;
        logic [3:0]  act;
        logic        over;
        logic [23:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          draw_start = 1'b0;
    logic          game_over = 1'b0;
    logic          frame_done = 1'b1;
    logic [NC-1:0] grid = '0;
    logic [3:0]    active_row = 4'd15;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt[2] = '{0, 0};
    int last_wr[2]  = '{0, 0};
    wr_t q0[$];
    wr_t q1[$];
    vec_t tbl[7];

    stacker_frame_painter_if #(.GRID_COLS(COLS), .GRID_ROWS(ROWS)) if0 ();
    stacker_frame_painter_if #(.GRID_COLS(COLS), .GRID_ROWS(ROWS)) if1 ();

    assign if0.draw_start = draw_start;
    assign if0.grid_bits  = grid;
    assign if0.active_row = active_row;
    assign if0.game_over  = game_over;
    assign if0.frame_done = frame_done;
    assign if1.draw_start = draw_start;
    assign if1.grid_bits  = grid;
    assign if1.active_row = active_row;
    assign if1.game_over  = game_over;
    assign if1.frame_done = frame_done;

    stacker_frame_painter #(.SYNC_TO_FRAME(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    stacker_frame_painter #(.SYNC_TO_FRAME(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic mon(input int d, input logic wr, input logic [14:0] a, input logic [23:0] dt,
                       input logic dd, input logic bz);
        wr_t e;
        if (wr) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL unexpected_write dut%0d: got addr %0h expected no write", d, a);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("wr_addr dut%0d", d), 64'(a), 64'(e.addr));
                check($sformatf("wr_data dut%0d addr %0d", d, e.addr), 64'(dt), 64'(e.data));
            end
            check($sformatf("wr_busy dut%0d", d), 64'(bz), 64'd1);
            last_wr[d] = cyc;
        end
        if (dd) begin
            done_cnt[d]++;
            check($sformatf("done_after_last_wr dut%0d", d), 64'(cyc), 64'(last_wr[d] + 1));
            check($sformatf("done_busy dut%0d", d), 64'(bz), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, if0.the_vga_draw_frame_write_a_pixel, if0.the_vga_draw_frame_write_mem_address,
            if0.the_vga_draw_frame_write_mem_data, if0.draw_done, if0.busy);
        mon(1, if1.the_vga_draw_frame_write_a_pixel, if1.the_vga_draw_frame_write_mem_address,
            if1.the_vga_draw_frame_write_mem_data, if1.draw_done, if1.busy);
    end

    function automatic logic [23:0] model_color(input logic [NC-1:0] g, input logic [3:0] act,
                                                input logic over, input int col, input int row);
        if (!g[row*COLS+col]) return 24'h000000;
        if (over)             return 24'hFFFFFF;
        if (row == int'(act)) return 24'hFF0000;
        return 24'h00FF00;
    endfunction

    task automatic push_frame(input logic [NC-1:0] g, input logic [3:0] act, input logic over,
                              input int n0, input int n1);
        wr_t e;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                e.addr = 15'(c * ROWS + r);
                e.data = model_color(g, act, over, c, r);
                if (c * ROWS + r < n0) q0.push_back(e);
                if (c * ROWS + r < n1) q1.push_back(e);
            end
        end
    endtask

    task automatic push_single(input int col, input int row, input logic [23:0] exp);
        wr_t e;
        for (int k = 0; k < NC; k++) begin
            e.addr = 15'(k);
            e.data = (k == col * ROWS + row) ? exp : 24'h000000;
            q0.push_back(e);
            q1.push_back(e);
        end
    endtask

    function automatic logic [NC-1:0] rand_grid();
        logic [NC-1:0] g;
        for (int i = 0; i < NC / 32; i++) g[i*32 +: 32] = $urandom;
        return g;
    endfunction

    task automatic pulse_start();
        @(posedge clk);
        #1 draw_start = 1'b1;
        @(posedge clk);
        #1 draw_start = 1'b0;
    endtask

    task automatic wait_done(input int t0, input int t1, input int budget);
        int n = 0;
        while ((done_cnt[0] < t0 || done_cnt[1] < t1) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("draw_done_reached dut0", 64'(done_cnt[0] >= t0), 64'd1);
        check("draw_done_reached dut1", 64'(done_cnt[1] >= t1), 64'd1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, " q0_drained"}, 64'(q0.size()), 64'd0);
        check({tag, " q1_drained"}, 64'(q1.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1;
        tbl[0] = '{3,  11, 4'd11, 1'b0, 24'hFF0000};
        tbl[1] = '{3,  11, 4'd15, 1'b0, 24'h00FF00};
        tbl[2] = '{0,  0,  4'd0,  1'b1, 24'hFFFFFF};
        tbl[3] = '{15, 11, 4'd11, 1'b1, 24'hFFFFFF};
        tbl[4] = '{7,  5,  4'd6,  1'b0, 24'h00FF00};
        tbl[5] = '{15, 0,  4'd0,  1'b0, 24'hFF0000};
        tbl[6] = '{0,  11, 4'd12, 1'b0, 24'h00FF00};

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst busy0", 64'(if0.busy), 64'd0);
        check("rst busy1", 64'(if1.busy), 64'd0);
        check("rst done0", 64'(if0.draw_done), 64'd0);
        check("rst strobe0", 64'(if0.the_vga_draw_frame_write_a_pixel), 64'd0);
        check("rst strobe1", 64'(if1.the_vga_draw_frame_write_a_pixel), 64'd0);
        check("rst addr0", 64'(if0.the_vga_draw_frame_write_mem_address), 64'd0);
        check("rst data0", 64'(if0.the_vga_draw_frame_write_mem_data), 64'd0);

        // Empty grid, start latency of both instances
        grid = '0;
        pulse_start();
        push_frame(grid, active_row, game_over, NC, NC);
        check("t1 busy0 same edge", 64'(if0.busy), 64'd1);
        check("t1 busy1 same edge", 64'(if1.busy), 64'd1);
        @(negedge clk);
        check("t1 strobe0 before first", 64'(if0.the_vga_draw_frame_write_a_pixel), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("t1 strobe0 first", 64'(if0.the_vga_draw_frame_write_a_pixel), 64'd1);
        check("t1 addr0 first", 64'(if0.the_vga_draw_frame_write_mem_address), 64'd0);
        check("t1 strobe1 via wait_sync", 64'(if1.the_vga_draw_frame_write_a_pixel), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("t1 strobe1 first", 64'(if1.the_vga_draw_frame_write_a_pixel), 64'd1);
        check("t1 addr1 first", 64'(if1.the_vga_draw_frame_write_mem_address), 64'd0);
        wait_done(1, 1, 500);
        repeat (5) @(posedge clk);
        #1;
        check_drained("t1");
        check("t1 busy0 after", 64'(if0.busy), 64'd0);
        check("t1 busy1 after", 64'(if1.busy), 64'd0);
        check("t1 done count0", 64'(done_cnt[0]), 64'd1);
        check("t1 done count1", 64'(done_cnt[1]), 64'd1);

        // Single occupied cell, colour priority table
        for (int i = 0; i < 7; i++) begin
            grid = '0;
            grid[tbl[i].row*COLS+tbl[i].col] = 1'b1;
            active_row = tbl[i].act;
            game_over  = tbl[i].over;
            b0 = done_cnt[0];
            b1 = done_cnt[1];
            pulse_start();
            push_single(tbl[i].col, tbl[i].row, tbl[i].exp);
            wait_done(b0 + 1, b1 + 1, 500);
            repeat (3) @(posedge clk);
            #1;
            check_drained($sformatf("t2 vec%0d", i));
        end

        // Frame sync hold-off
        frame_done = 1'b0;
        game_over  = 1'b0;
        active_row = 4'd5;
        grid = rand_grid();
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        pulse_start();
        push_frame(grid, active_row, game_over, NC, NC);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("t3 strobe1 held", 64'(if1.the_vga_draw_frame_write_a_pixel), 64'd0);
            check("t3 busy1 waiting", 64'(if1.busy), 64'd1);
            @(posedge clk);
        end
        #1 frame_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3 strobe1 paint entry", 64'(if1.the_vga_draw_frame_write_a_pixel), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("t3 strobe1 first", 64'(if1.the_vga_draw_frame_write_a_pixel), 64'd1);
        check("t3 addr1 first", 64'(if1.the_vga_draw_frame_write_mem_address), 64'd0);
        wait_done(b0 + 1, b1 + 1, 500);
        repeat (3) @(posedge clk);
        #1;
        check_drained("t3");

        // Snapshot isolation and one collapsed pending repaint
        grid = rand_grid();
        active_row = 4'd4;
        game_over  = 1'b0;
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        pulse_start();
        push_frame(grid, active_row, game_over, NC, NC);
        repeat (20) @(posedge clk);
        #1;
        grid = rand_grid();
        game_over  = 1'b1;
        active_row = 4'd7;
        repeat (40) @(posedge clk);
        pulse_start();
        pulse_start();
        push_frame(grid, active_row, game_over, NC, NC);
        wait_done(b0 + 2, b1 + 2, 900);
        repeat (20) @(posedge clk);
        #1;
        check_drained("t4");
        check("t4 done pulses0", 64'(done_cnt[0] - b0), 64'd2);
        check("t4 done pulses1", 64'(done_cnt[1] - b1), 64'd2);

        // Reset in the middle of a frame
        grid = rand_grid();
        game_over  = 1'b0;
        active_row = 4'd2;
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        pulse_start();
        push_frame(grid, active_row, game_over, 100, 99);
        repeat (100) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t5 strobe0 reset", 64'(if0.the_vga_draw_frame_write_a_pixel), 64'd0);
        check("t5 strobe1 reset", 64'(if1.the_vga_draw_frame_write_a_pixel), 64'd0);
        check("t5 busy0 reset", 64'(if0.busy), 64'd0);
        check("t5 busy1 reset", 64'(if1.busy), 64'd0);
        check("t5 done0 reset", 64'(if0.draw_done), 64'd0);
        check_drained("t5 abort");
        repeat (20) @(posedge clk);
        #1;
        check("t5 no done0", 64'(done_cnt[0] - b0), 64'd0);
        check("t5 no done1", 64'(done_cnt[1] - b1), 64'd0);
        pulse_start();
        push_frame(grid, active_row, game_over, NC, NC);
        wait_done(b0 + 1, b1 + 1, 500);
        repeat (3) @(posedge clk);
        #1;
        check_drained("t5 restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
